tc_ram_param: RTL and testbench
===============================

TC_RAM_PARAM -- requirements
Module: tc_ram_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1..64.
REQ-002 SHALL have parameter ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words, legal range 1..12.
REQ-003 SHALL have port clk  input  1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1: read request for the current cycle.
REQ-006 SHALL have port load_addr  input  ADDR_W: read address.
REQ-007 SHALL have port out  output  WIDTH: registered read data, 0 when no read is pending.
REQ-008 SHALL have port save  input  1: write request for the current cycle.
REQ-009 SHALL have port save_addr  input  ADDR_W: write address.
REQ-010 SHALL have port in  input  WIDTH: write data.
REQ-011 SHALL have port clear  input  1: synchronous request to zero the whole array.
REQ-012 SHALL have port busy  output  1: high while a clear sweep is running.

Function
REQ-013 SHALL implement a state machine with states CLEAR and READY, plus a sweep counter of width ADDR_W.
REQ-014 CLEAR SHALL write 0 to mem[counter] each cycle, increment the counter, and enter READY after writing index DEPTH-1, taking exactly DEPTH cycles.
REQ-015 READY SHALL enter CLEAR with the counter at 0 on the cycle after clear=1 is sampled.
REQ-016 clear=1 during CLEAR SHALL restart the counter at 0.
REQ-017 busy SHALL be 1 exactly while the state is CLEAR.
REQ-018 In READY, with load=1 sampled at edge N, out SHALL equal mem[load_addr] from edge N until edge N+1: one-cycle latency.
REQ-019 With load=0 sampled, or in CLEAR, out SHALL be 0 for the next cycle.
REQ-020 In READY, save=1 SHALL write in to mem[save_addr] at the rising edge.
REQ-021 save SHALL be ignored in CLEAR; load in CLEAR SHALL return 0.
REQ-022 save and load to different addresses in one cycle SHALL both complete independently.
REQ-023 In READY, clear=1 together with save=1 SHALL perform the write; the following sweep then zeroes it.
REQ-024 Addresses SHALL always be in range; no wrap logic beyond ADDR_W bits.

Reset
REQ-025 rst=0 SHALL asynchronously force state=CLEAR, counter=0, out=0 and busy=1.
REQ-026 Array contents SHALL NOT be reset directly; the sweep after rst rises zeroes them over DEPTH cycles.
REQ-027 rst asserted mid-sweep SHALL restart the sweep from index 0.
REQ-028 No request SHALL be honoured while rst=0.

Configuration
REQ-029 Macro TC_RAM_PARAM_BYPASS_EN SHALL select same-address read-during-write behaviour.
REQ-030 With TC_RAM_PARAM_BYPASS_EN defined, load and save to the same address at the same edge SHALL return in on out (write-first).
REQ-031 Without TC_RAM_PARAM_BYPASS_EN, the same case SHALL return the previous contents (read-first); the write still completes.

Verification
REQ-032 Reset then idle, WIDTH=8, ADDR_W=8 -> busy=1 for 256 cycles after rst rises, then 0; a load of every address returns 0x00.
REQ-033 save addr 0x10 data 0xA5, then load 0x10 next cycle -> out=0xA5 one cycle after the load; out=0 on the cycle after load drops.
REQ-034 Same-cycle save 0x20/0x3C with load 0x20 (prior 0x00) -> out=0x3C with the macro defined, out=0x00 without; a later load returns 0x3C in both builds.
REQ-035 clear pulse after filling addr 0xFF with 0x77 -> busy high for 256 cycles, saves during the sweep are dropped, and a later load of 0xFF returns 0x00.
REQ-036 rst pulsed low at sweep index 100 -> out=0 at once, and busy stays high 256 cycles after rst rises.
REQ-037 WIDTH=16, ADDR_W=4 -> sweep lasts 16 cycles; save 0xBEEF at addr 15 then load addr 15 -> out=0xBEEF.

Source files
------------

// File: rtl/tc_ram_param.sv
// tc_ram_param: DEPTH x WIDTH RAM, one-cycle registered read, DEPTH-cycle zeroing sweep after reset/clear.
// Define TC_RAM_PARAM_BYPASS_EN for write-first same-address read-during-write (default is read-first).
module tc_ram_param #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [WIDTH-1:0]  out,
  input  logic              save,
  input  logic [ADDR_W-1:0] save_addr,
  input  logic [WIDTH-1:0]  in,
  input  logic              clear,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [WIDTH-1:0]  mem_wd;
  logic [WIDTH-1:0]  rd_dat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    mem_we  = 1'b0;
    mem_wa  = save_addr;
    mem_wd  = in;
    rd_dat  = mem[load_addr];
`ifdef TC_RAM_PARAM_BYPASS_EN
    if (save && (save_addr == load_addr)) begin
      rd_dat = in;
    end
`endif
    if (state_q == ST_CLEAR) begin
      // Sweep owns the write port; user save/load are ignored and reads return 0.
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
      if (clear) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
        end
      end
    end else begin
      mem_we = save;
      if (load) begin
        out_d = rd_dat;
      end
      if (clear) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end
  end

  // Array has no reset; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_tc_ram_param.sv
// Bench for tc_ram_param: default 8x256 instance plus a 16x16 instance; reference array model.
module tb_tc_ram_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TC_RAM_PARAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       rst, load, save, clear, busy;
  logic [7:0] load_addr, save_addr, din, out;

  logic        s_rst, s_load, s_save, s_clear, s_busy;
  logic [3:0]  s_la, s_sa;
  logic [15:0] s_in, s_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [256];

  tc_ram_param u_dut (
    .clk(clk), .rst(rst), .load(load), .load_addr(load_addr), .out(out),
    .save(save), .save_addr(save_addr), .in(din), .clear(clear), .busy(busy)
  );

  tc_ram_param #(.WIDTH(16), .ADDR_W(4)) u_small (
    .clk(clk), .rst(s_rst), .load(s_load), .load_addr(s_la), .out(s_out),
    .save(s_save), .save_addr(s_sa), .in(s_in), .clear(s_clear), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load = 1'b0; save = 1'b0; clear = 1'b0;
  endtask

  task automatic model_zero();
    for (int a = 0; a < 256; a++) mdl[a] = 8'h00;
  endtask

  task automatic wait_sweep(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < exp_cycles + 64) begin
      tick();
      n++;
    end
    checks++;
    if (n !== exp_cycles) begin
      failures++;
      $display("FAIL %s busy_cycles actual=%0d required=%0d", name, n, exp_cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; idle();
    repeat (3) tick();
    checks++;
    if (out !== 8'h00) begin failures++; $display("FAIL reset_out actual=%h required=00", out); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy actual=%b required=1", busy); end
    rst = 1'b1;
    wait_sweep("reset_sweep", 256);
    model_zero();
  endtask

  task automatic test_zero_fill();
    for (int a = 0; a < 256; a++) begin
      load = 1'b1; load_addr = 8'(a);
      tick();
      checks++;
      if (out !== 8'h00) begin
        failures++; $display("FAIL zero_fill addr=%0d actual=%h required=00", a, out);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    save = 1'b1; save_addr = 8'h10; din = 8'hA5;
    tick();
    mdl[8'h10] = 8'hA5;
    save = 1'b0; load = 1'b1; load_addr = 8'h10;
    tick();
    checks++;
    if (out !== 8'hA5) begin failures++; $display("FAIL write_read actual=%h required=a5", out); end
    load = 1'b0;
    tick();
    checks++;
    if (out !== 8'h00) begin failures++; $display("FAIL read_drop actual=%h required=00", out); end
  endtask

  task automatic test_rdw();
    logic [7:0] exp;
    exp = BYP ? 8'h3C : 8'h00;
    save = 1'b1; save_addr = 8'h20; din = 8'h3C; load = 1'b1; load_addr = 8'h20;
    tick();
    mdl[8'h20] = 8'h3C;
    save = 1'b0;
    checks++;
    if (out !== exp) begin failures++; $display("FAIL rdw_same_edge actual=%h required=%h", out, exp); end
    tick();
    checks++;
    if (out !== 8'h3C) begin failures++; $display("FAIL rdw_later actual=%h required=3c", out); end
    idle();
  endtask

  task automatic test_random();
    logic       ls, ss;
    logic [7:0] la, sa, d, exp;
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      ls = 1'($urandom_range(0, 1));
      ss = 1'($urandom_range(0, 1));
      la = 8'($urandom);
      sa = ($urandom_range(0, 3) == 0) ? la : 8'($urandom);
      d  = 8'($urandom);
      if (!ls) exp = 8'h00;
      else if (ss && sa == la && BYP) exp = d;
      else exp = mdl[la];
      load = ls; load_addr = la; save = ss; save_addr = sa; din = d;
      tick();
      if (ss) mdl[sa] = d;
      checks++;
      if (out !== exp) begin
        failures++;
        if (bad < 10) $display("FAIL random i=%0d addr=%h actual=%h required=%h", i, la, out, exp);
        bad++;
      end
    end
    idle();
  endtask

  task automatic test_clear();
    int n;
    save = 1'b1; save_addr = 8'hFF; din = 8'h77;
    tick();
    mdl[8'hFF] = 8'h77;
    save = 1'b0; load = 1'b1; load_addr = 8'hFF;
    tick();
    checks++;
    if (out !== 8'h77) begin failures++; $display("FAIL clear_prefill actual=%h required=77", out); end
    load = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL clear_enter busy=%b required=1", busy); end
    // A second clear at sweep index 50 restarts the count: 51 + 256 edges in total.
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      save = 1'b1; save_addr = 8'h00; din = 8'h55;
      load = 1'b1; load_addr = 8'($urandom);
      clear = (n == 50);
      tick();
      n++;
      checks++;
      if (out !== 8'h00) begin failures++; $display("FAIL clear_load n=%0d actual=%h required=00", n, out); end
    end
    idle();
    model_zero();
    checks++;
    if (n !== 307) begin failures++; $display("FAIL clear_restart_cycles actual=%0d required=307", n); end
    load = 1'b1; load_addr = 8'hFF;
    tick();
    checks++;
    if (out !== mdl[8'hFF]) begin failures++; $display("FAIL clear_ff actual=%h required=%h", out, mdl[8'hFF]); end
    load_addr = 8'h00;
    tick();
    checks++;
    if (out !== mdl[8'h00]) begin failures++; $display("FAIL clear_drop_save actual=%h required=%h", out, mdl[8'h00]); end
    idle();
  endtask

  task automatic test_async_reset();
    save = 1'b1; save_addr = 8'h30; din = 8'h9C;
    tick();
    mdl[8'h30] = 8'h9C;
    save = 1'b0; load = 1'b1; load_addr = 8'h30;
    tick();
    checks++;
    if (out !== 8'h9C) begin failures++; $display("FAIL arst_prefill actual=%h required=9c", out); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out !== 8'h00) begin failures++; $display("FAIL arst_out_async actual=%h required=00", out); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL arst_busy_async actual=%b required=1", busy); end
    save = 1'b1; save_addr = 8'h31; din = 8'h11;
    repeat (3) tick();
    checks++;
    if (out !== 8'h00) begin failures++; $display("FAIL arst_hold_out actual=%h required=00", out); end
    idle();
    rst = 1'b1;
    wait_sweep("arst_sweep", 256);
    model_zero();
    load = 1'b1; load_addr = 8'h31;
    tick();
    checks++;
    if (out !== mdl[8'h31]) begin failures++; $display("FAIL arst_no_save actual=%h required=%h", out, mdl[8'h31]); end
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (100) tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midsweep_busy actual=%b required=1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out !== 8'h00) begin failures++; $display("FAIL midsweep_out actual=%h required=00", out); end
    tick();
    rst = 1'b1;
    wait_sweep("midsweep_restart", 256);
  endtask

  task automatic test_small();
    int n;
    repeat (2) tick();
    checks++;
    if (s_busy !== 1'b1 || s_out !== 16'h0000) begin
      failures++; $display("FAIL small_reset busy=%b out=%h required busy=1 out=0000", s_busy, s_out);
    end
    s_rst = 1'b1;
    n = 0;
    while (s_busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL small_sweep actual=%0d required=16", n); end
    s_save = 1'b1; s_sa = 4'd15; s_in = 16'hBEEF;
    tick();
    s_save = 1'b0; s_load = 1'b1; s_la = 4'd15;
    tick();
    checks++;
    if (s_out !== 16'hBEEF) begin failures++; $display("FAIL small_read actual=%h required=beef", s_out); end
    s_load = 1'b0;
    tick();
    checks++;
    if (s_out !== 16'h0000) begin failures++; $display("FAIL small_drop actual=%h required=0000", s_out); end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; save = 1'b0; clear = 1'b0;
    load_addr = 8'h00; save_addr = 8'h00; din = 8'h00;
    s_rst = 1'b0; s_load = 1'b0; s_save = 1'b0; s_clear = 1'b0;
    s_la = 4'h0; s_sa = 4'h0; s_in = 16'h0000;
    model_zero();
    test_reset();
    test_zero_fill();
    test_write_read();
    test_rdw();
    test_random();
    test_clear();
    test_async_reset();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
